// File: rtl/oc_port_pkg.sv
// Shared types and defaults for the chamber port bank.
package oc_port_pkg;

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } port_state_t;

  // Port 0 opens while pressurised, port 1 while evacuated.
  localparam logic [1:0] DEFAULT_REQ_STATE = 2'b10;

endpackage

// File: rtl/oc_port_fsm.sv
// One chamber port: door state, travel counter, denial pulse and sticky fault.
module oc_port_fsm
  import oc_port_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        permit,
  input  logic        won,
  input  logic        mismatch,
  output port_state_t state,
  output logic        port_open,
  output logic        moving,
  output logic        denied,
  output logic        fault,
  output logic        active_nxt_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TRAVEL_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  port_state_t      nxt_state;
  logic             nxt_denied;
  logic             nxt_fault;

  // Next-state logic; a reversal mirrors the counter so remaining travel equals elapsed travel.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_denied = 1'b0;
    nxt_fault  = fault;
    case (state)
      CLOSED: begin
        if (req) begin
          if (permit && won) begin
            nxt_state = OPENING;
            nxt_cnt   = '0;
          end else begin
            nxt_denied = 1'b1;
          end
        end
      end
      OPENING: begin
        if (req) begin
          nxt_state = CLOSING;
          nxt_cnt   = LAST - cnt;
        end else if (cnt == LAST) begin
          nxt_state = OPEN;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      OPEN: begin
        if (mismatch) begin
          nxt_state = CLOSING;
          nxt_cnt   = '0;
          nxt_fault = 1'b1;
        end else if (req) begin
          nxt_state = CLOSING;
          nxt_cnt   = '0;
        end
      end
      CLOSING: begin
        if (req && permit) begin
          nxt_state = OPENING;
          nxt_cnt   = LAST - cnt;
        end else if (cnt == LAST) begin
          nxt_state = CLOSED;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      default: begin
        nxt_state = CLOSED;
        nxt_cnt   = '0;
      end
    endcase
  end

  assign active_nxt_c = (nxt_state != CLOSED);

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLOSED;
      cnt       <= '0;
      denied    <= 1'b0;
      fault     <= 1'b0;
      port_open <= 1'b0;
      moving    <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      denied    <= nxt_denied;
      fault     <= nxt_fault;
      port_open <= (nxt_state == OPEN);
      moving    <= (nxt_state == OPENING) || (nxt_state == CLOSING);
    end
  end

endmodule

// File: rtl/oc_port_bank.sv
// Bank of chamber ports with edge-detected switches, pressure gating and a single-open interlock.
module oc_port_bank
  import oc_port_pkg::*;
#(
  parameter int unsigned          NUM_PORTS     = 2,
  parameter int unsigned          TRAVEL_CYCLES = 8,
  parameter int unsigned          CNT_W         = 4,
  parameter logic [NUM_PORTS-1:0] REQ_STATE     = NUM_PORTS'(DEFAULT_REQ_STATE)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NUM_PORTS-1:0] SwitchFlip,
  input  logic                 EVState,
  output logic [NUM_PORTS-1:0] PortOpen,
  output logic [NUM_PORTS-1:0] PortMoving,
  output logic [NUM_PORTS-1:0] Denied,
  output logic [NUM_PORTS-1:0] Fault,
  output logic                 ChamberLock
);

  logic [NUM_PORTS-1:0] sw_q;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] permit;
  logic [NUM_PORTS-1:0] won;
  logic [NUM_PORTS-1:0] mismatch;
  logic [NUM_PORTS-1:0] closed;
  logic [NUM_PORTS-1:0] active_nxt;
  logic                 taken;
  port_state_t          state [NUM_PORTS];

  // Resetting to ones keeps a switch held high through reset from looking like a new edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) sw_q <= '1;
    else       sw_q <= SwitchFlip;
  end

  assign req      = SwitchFlip & ~sw_q;
  assign mismatch = {NUM_PORTS{EVState}} ^ REQ_STATE;

  // Interlock: a port may open only when all others are closed; lowest index wins ties.
  always_comb begin
    closed = '0;
    permit = '0;
    won    = '0;
    taken  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      closed[i] = (state[i] == CLOSED);
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      permit[i] = (EVState == REQ_STATE[i]) && (&(closed | (NUM_PORTS'(1) << i)));
      won[i]    = ~taken;
      taken     = taken | (req[i] & permit[i]);
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    oc_port_fsm #(
      .TRAVEL_CYCLES (TRAVEL_CYCLES),
      .CNT_W         (CNT_W)
    ) u_fsm (
      .clk          (Clock),
      .rst          (Reset),
      .req          (req[g]),
      .permit       (permit[g]),
      .won          (won[g]),
      .mismatch     (mismatch[g]),
      .state        (state[g]),
      .port_open    (PortOpen[g]),
      .moving       (PortMoving[g]),
      .denied       (Denied[g]),
      .fault        (Fault[g]),
      .active_nxt_c (active_nxt[g])
    );
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) ChamberLock <= 1'b0;
    else       ChamberLock <= |active_nxt;
  end

endmodule

// File: doc/oc_port_bank.md
Name: oc_port_bank

Overview:
- Parametrised successor to the single open/close port controller.
- Manages NUM_PORTS chamber ports, each driven by a toggle switch.
- Adds per-port pressure gating, finite door travel time, mid-travel reversal, single-open interlock with fixed priority, denial pulses and sticky fault flags.
- Sits between the switch inputs and the door actuators. It exports ChamberLock so the pressure controller freezes EVState while any port is not closed.

Parameters:
- NUM_PORTS, 2, number of ports/switches.
- TRAVEL_CYCLES, 8, clock cycles a door spends OPENING or CLOSING (must be ≥1).
- CNT_W, 4, travel counter width; must satisfy 2^CNT_W > TRAVEL_CYCLES.
- REQ_STATE, 2'b10, bit i is the EVState value port i requires to open (default: port0 opens pressurised (0), port1 opens evacuated (1)).

Ports:
- Clock  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- SwitchFlip  in  NUM_PORTS  per-port toggle switch level; a 0→1 edge is one request.
- EVState  in  1  chamber state: 0 = pressurised, 1 = evacuated.
- PortOpen  out  NUM_PORTS  1 while port is fully OPEN.
- PortMoving  out  NUM_PORTS  1 while port is OPENING or CLOSING.
- Denied  out  NUM_PORTS  one-cycle pulse when an open request is refused.
- Fault  out  NUM_PORTS  sticky; set on forced close; cleared only by Reset.
- ChamberLock  out  1  OR over all ports of (state != CLOSED).

Behaviour:
- Reset (async, any time including mid-travel):
  - All ports go to CLOSED; counters 0.
  - PortOpen, PortMoving, Denied, Fault and ChamberLock are all 0.
  - The edge register sw_q resets to all ones, so a switch held high through reset produces no request.
- Request detection: req[i] = SwitchFlip[i] & ~sw_q[i], evaluated at the posedge. sw_q <= SwitchFlip every cycle. The resulting transition is visible after that same edge.
- permit[i] = (EVState == REQ_STATE[i]) and every other port is CLOSED.
- Simultaneous open requests: the lowest index wins. Losers get a Denied pulse on the next cycle and stay in their current state.
- Per-port states (CLOSED, OPENING, OPEN, CLOSING):
  - CLOSED: req & permit & won → OPENING, cnt=0. req & !(permit & won) → Denied=1 for one cycle, stay CLOSED.
  - OPENING: cnt increments each cycle. When cnt reaches TRAVEL_CYCLES-1 → OPEN, so OPENING lasts exactly TRAVEL_CYCLES cycles. req → CLOSING with cnt = TRAVEL_CYCLES-1-cnt (reversal; remaining travel equals elapsed travel).
  - OPEN: req → CLOSING, cnt=0. If EVState != REQ_STATE[i] → CLOSING and Fault[i] <= 1 (forced close).
  - CLOSING: cnt increments; at TRAVEL_CYCLES-1 → CLOSED. req & permit → OPENING with mirrored cnt. req & !permit → ignored, no Denied.
- Priority within a port for the same cycle: forced close beats req.
- Outputs are registered decodes of state, with no combinational path from SwitchFlip.
- ChamberLock is asserted from the first OPENING cycle through the last CLOSING cycle.
- A switch held high yields exactly one request; it must fall and rise again to request again.

Decomposition:
- Package oc_port_pkg holds:
  - port_state_t enum: CLOSED=2'd0, OPENING=2'd1, OPEN=2'd2, CLOSING=2'd3.
  - Helper constant for the default REQ_STATE.
- Sub-module oc_port_fsm holds one port's state, counter, Denied register and Fault register. Its inputs are req, permit, won and mismatch.
- The top level generates NUM_PORTS instances plus edge detection, permit/priority logic and the ChamberLock OR.

Test Plan:
All scenarios use NUM_PORTS=2, TRAVEL_CYCLES=4, REQ_STATE=2'b10.
1. Reset, EVState=0, SwitchFlip[0] 0→1 → PortMoving[0]=1 for 4 cycles, then PortOpen[0]=1. ChamberLock=1 from the first OPENING cycle. Second edge → 4 CLOSING cycles, then all outputs 0.
2. EVState=0, SwitchFlip[1] rises → Denied[1] one-cycle pulse, port1 stays CLOSED, ChamberLock stays 0.
3. Port0 OPEN, EVState=1, SwitchFlip[1] rises → Denied[1]=1 (interlock). EVState held at 1 → port0 forced CLOSING, Fault[0]=1 and it stays 1 after CLOSED until Reset.
4. Port0 opening, second edge after 1 OPENING cycle → CLOSING lasts exactly 1 cycle, then CLOSED (reversal).
5. EVState=0, REQ_STATE=2'b00 build, both switches rise same cycle → port0 OPENING, Denied[1] pulse.
6. Reset asserted mid-OPENING, with SwitchFlip held high through release → immediate CLOSED with all outputs 0, and no new request after release.
